prog_loader: RTL and testbench

Serial program loader for the 17-bit instruction memory fetched by the processor core. It accepts instruction words bit-serially over a valid/ready handshake and writes them into a 32-entry program RAM. It exposes an asynchronous read port used by the fetch logic, plus status flags that gate processor start. It is the write side of the program-memory interface; the core's fetch path is the read side.

---
 rtl/prog_pkg.sv | 24 ++
 rtl/prog_ram.sv | 32 +++
 rtl/prog_loader.sv | 150 +++++++++++++++
 tb/tb_prog_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_pkg.sv
// prog_pkg: shared constants and the loader state type for the program-memory
// write path (prog_loader) and its RAM (prog_ram).
package prog_pkg;

  localparam int IW    = 17;  // instruction word width
  localparam int AW    = 5;   // program address width
  localparam int DEPTH = 32;  // number of program words

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } load_state_e;

  // A session length is usable only if it names at least one word and
  // does not run past the end of the program RAM.
  function automatic logic len_legal(input logic [AW:0] len);
    logic [AW:0] depth_w;
    depth_w = (AW+1)'(DEPTH);
    return (len != {(AW+1){1'b0}}) && (len <= depth_w);
  endfunction

endpackage

// File: rtl/prog_ram.sv
// prog_ram: DEPTH x IW program RAM shared between the loader and fetch.
// Ports:
//   clk   - write clock (rising edge)
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - fetch read address
//   rdata - mem[raddr], combinational
// Contents are deliberately not reset so a program survives rst_n.
module prog_ram
  import prog_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem_r [DEPTH];

  // Single synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/prog_loader.sv
// prog_loader: bit-serial program loader. Shifts instruction words in MSB
// first over a valid/ready handshake and writes them to consecutive RAM
// addresses starting at 0.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   load_start       - pulse; starts (or restarts) a session of load_len words
//   load_len         - session length, legal 1..DEPTH
//   ser_valid/data   - serial bit stream (MSB first)
//   ser_ready        - high while a bit can be accepted
//   rd_addr/rd_data  - asynchronous fetch read port
//   load_busy        - session in progress
//   load_done        - all words written; held until the next accepted start
//   word_count       - words written in this session
//   err_len          - sticky: start requested with an illegal length
//   err_overrun      - sticky: serial data offered after the session finished
module prog_loader
  import prog_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic [AW:0]   load_len,
  input  logic          ser_valid,
  input  logic          ser_data,
  output logic          ser_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [IW-1:0] rd_data,
  output logic          load_busy,
  output logic          load_done,
  output logic [AW:0]   word_count,
  output logic          err_len,
  output logic          err_overrun
);

  load_state_e   state_r;
  logic [IW-1:0] shreg_r;
  logic [4:0]    bitcnt_r;
  logic [AW-1:0] ptr_r;
  logic [AW:0]   len_r;
  logic [AW:0]   word_count_r;
  logic          load_done_r;
  logic          err_len_r;
  logic          err_overrun_r;
  logic          ser_ready_r;
  logic          load_busy_r;
  logic          mem_we_s;
  logic [AW:0]   word_count_inc_s;

  // A restart in the write cycle drops that write.
  assign mem_we_s         = (state_r == ST_WRITE) && !load_start;
  assign word_count_inc_s = word_count_r + {{AW{1'b0}}, 1'b1};

  // Session FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      shreg_r       <= {IW{1'b0}};
      bitcnt_r      <= 5'd0;
      ptr_r         <= {AW{1'b0}};
      len_r         <= {(AW+1){1'b0}};
      word_count_r  <= {(AW+1){1'b0}};
      load_done_r   <= 1'b0;
      err_len_r     <= 1'b0;
      err_overrun_r <= 1'b0;
      ser_ready_r   <= 1'b0;
      load_busy_r   <= 1'b0;
    end else if (load_start) begin
      // Start takes priority in every state; any partial word is discarded.
      if (len_legal(load_len)) begin
        state_r       <= ST_SHIFT;
        bitcnt_r      <= 5'd0;
        ptr_r         <= {AW{1'b0}};
        len_r         <= load_len;
        word_count_r  <= {(AW+1){1'b0}};
        load_done_r   <= 1'b0;
        err_len_r     <= 1'b0;
        err_overrun_r <= 1'b0;
        ser_ready_r   <= 1'b1;
        load_busy_r   <= 1'b1;
      end else begin
        err_len_r <= 1'b1;
        // An illegal restart still aborts a running session.
        if ((state_r == ST_SHIFT) || (state_r == ST_WRITE)) begin
          state_r     <= ST_IDLE;
          ser_ready_r <= 1'b0;
          load_busy_r <= 1'b0;
        end
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          ser_ready_r <= 1'b0;
          load_busy_r <= 1'b0;
        end
        ST_SHIFT: begin
          if (ser_valid && ser_ready_r) begin
            shreg_r <= {shreg_r[IW-2:0], ser_data};
            if (bitcnt_r == 5'(IW - 1)) begin
              state_r     <= ST_WRITE;
              ser_ready_r <= 1'b0;
            end else begin
              bitcnt_r <= bitcnt_r + 5'd1;
            end
          end
        end
        ST_WRITE: begin
          word_count_r <= word_count_inc_s;
          if (word_count_inc_s == len_r) begin
            // Last word: ptr stays put so it never wraps past DEPTH-1.
            state_r     <= ST_DONE;
            load_done_r <= 1'b1;
            load_busy_r <= 1'b0;
          end else begin
            state_r     <= ST_SHIFT;
            ptr_r       <= ptr_r + {{(AW-1){1'b0}}, 1'b1};
            bitcnt_r    <= 5'd0;
            ser_ready_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (ser_valid) begin
            err_overrun_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          ser_ready_r <= 1'b0;
          load_busy_r <= 1'b0;
        end
      endcase
    end
  end

  prog_ram u_ram (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (ptr_r),
    .wdata (shreg_r),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign ser_ready   = ser_ready_r;
  assign load_busy   = load_busy_r;
  assign load_done   = load_done_r;
  assign word_count  = word_count_r;
  assign err_len     = err_len_r;
  assign err_overrun = err_overrun_r;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  import prog_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic [AW:0]   load_len;
  logic          ser_valid;
  logic          ser_data;
  logic          ser_ready;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data;
  logic          load_busy;
  logic          load_done;
  logic [AW:0]   word_count;
  logic          err_len;
  logic          err_overrun;

  prog_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_len    (load_len),
    .ser_valid   (ser_valid),
    .ser_data    (ser_data),
    .ser_ready   (ser_ready),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .word_count  (word_count),
    .err_len     (err_len),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Scoreboard entry: expected session length and start-to-done latency.
  typedef struct {
    int len;
    int lat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Reference model: program RAM contents and pending stimulus.
  logic [IW-1:0] ref_mem [DEPTH];
  logic [IW-1:0] wq[$];
  int            gap_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising load_done is matched against the scoreboard.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && load_done === 1'b1 && prev_done !== 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_latency", 64'(cyc_cnt - start_cyc), 64'(mon_e.lat));
        check("word_count", 64'(word_count), 64'(mon_e.len));
        check("busy_at_done", 64'(load_busy), 64'd0);
      end
    end
    prev_done = load_done;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int len);
    load_start = 1'b1;
    load_len   = len[AW:0];
    cyc();
    load_start = 1'b0;
    start_cyc  = cyc_cnt;
  endtask

  // Sends one full word (gaps from gap_q before each bit) plus its write cycle.
  task automatic send_word(input logic [IW-1:0] w);
    int g;
    for (int b = IW - 1; b >= 0; b--) begin
      g = gap_q.pop_front();
      repeat (g) begin
        ser_valid = 1'b0;
        cyc();
      end
      ser_valid = 1'b1;
      ser_data  = w[b];
      check("ready_in_shift", 64'(ser_ready), 64'd1);
      cyc();
    end
    ser_valid = 1'b0;
    check("ready_in_write", 64'(ser_ready), 64'd0);
    check("busy_in_write", 64'(load_busy), 64'd1);
    cyc();
  endtask

  task automatic send_partial(input logic [IW-1:0] w, input int nbits);
    for (int b = IW - 1; b > IW - 1 - nbits; b--) begin
      ser_valid = 1'b1;
      ser_data  = w[b];
      cyc();
    end
    ser_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      cyc();
      t++;
    end
    check("done_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Full session: words come from wq; gap per bit uniform in glo..ghi.
  task automatic load(input int len, input int glo, input int ghi);
    exp_t e;
    int   sum;
    sum = 0;
    gap_q.delete();
    for (int i = 0; i < len * IW; i++) begin
      gap_q.push_back(int'($urandom_range(ghi, glo)));
      sum += gap_q[i];
    end
    e.len = len;
    e.lat = 18 * len + sum;
    sb.push_back(e);
    start(len);
    check("err_len_cleared", 64'(err_len), 64'd0);
    check("overrun_cleared", 64'(err_overrun), 64'd0);
    for (int i = 0; i < len; i++) begin
      send_word(wq[i]);
      ref_mem[i] = wq[i];
    end
    wait_done();
  endtask

  task automatic check_mem(input int n);
    for (int i = 0; i < n; i++) begin
      rd_addr = i[AW-1:0];
      @(negedge clk);
      check($sformatf("mem[%0d]", i), 64'(rd_data), 64'(ref_mem[i]));
    end
    cyc();
  endtask

  task automatic rand_words(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(IW'($urandom));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 64'(load_busy), 64'd0);
    check({tag, "_ready"}, 64'(ser_ready), 64'd0);
    check({tag, "_done"}, 64'(load_done), 64'd0);
    check({tag, "_wc"}, 64'(word_count), 64'd0);
    check({tag, "_err_len"}, 64'(err_len), 64'd0);
    check({tag, "_err_ovr"}, 64'(err_overrun), 64'd0);
  endtask

  initial begin
    int len;
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_len   = '0;
    ser_valid  = 1'b0;
    ser_data   = 1'b0;
    rd_addr    = '0;
    repeat (3) cyc();
    check_idle_zero("reset");
    rst_n = 1'b1;
    cyc();

    // Three known words, continuous stream.
    wq.delete();
    wq.push_back(17'h0E104);
    wq.push_back(17'h0E201);
    wq.push_back(17'h0E401);
    load(3, 0, 0);
    check_mem(3);

    // Same words, valid low between every bit.
    load(3, 1, 1);
    check_mem(3);

    // Illegal lengths.
    start(0);
    check("len0_err", 64'(err_len), 64'd1);
    check("len0_busy", 64'(load_busy), 64'd0);
    check("len0_ready", 64'(ser_ready), 64'd0);
    start(33);
    check("len33_err", 64'(err_len), 64'd1);
    check("len33_busy", 64'(load_busy), 64'd0);
    check("len33_ready", 64'(ser_ready), 64'd0);
    check_mem(3);

    // Full-depth load, then an overrun bit.
    rand_words(DEPTH);
    load(DEPTH, 0, 0);
    check("full_wc", 64'(word_count), 64'(DEPTH));
    check_mem(DEPTH);
    ser_valid = 1'b1;
    ser_data  = 1'b1;
    cyc();
    ser_valid = 1'b0;
    check("overrun_set", 64'(err_overrun), 64'd1);
    check("overrun_done_held", 64'(load_done), 64'd1);
    check_mem(1);

    // Restart after 9 bits of word 0.
    start(2);
    send_partial(IW'($urandom), 9);
    wq.delete();
    wq.push_back(17'h1F840);
    load(1, 0, 0);
    check_mem(1);

    // Reset during word 2 of 4.
    rand_words(4);
    start(4);
    gap_q.delete();
    for (int i = 0; i < 2 * IW; i++) gap_q.push_back(0);
    send_word(wq[0]);
    ref_mem[0] = wq[0];
    send_word(wq[1]);
    ref_mem[1] = wq[1];
    send_partial(wq[2], 5);
    rst_n = 1'b0;
    #2;
    check_idle_zero("midreset");
    cyc();
    rst_n = 1'b1;
    cyc();
    check_idle_zero("after_reset");
    check_mem(2);

    // Random sessions with random stalls.
    for (int k = 0; k < 4; k++) begin
      len = int'($urandom_range(8, 1));
      rand_words(len);
      load(len, 0, 2);
      check_mem(len);
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
